// File: rtl/pool_window_gen_pkg.sv
// Shared types and constants for the 2x2 pooling window generator.
package pool_pkg;

  localparam int POOL_DATA_W = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAIR = 2'd1,
    S_TAIL = 2'd2
  } pool_state_e;

endpackage

// File: rtl/pool_window_gen_line_buf.sv
// One-row pixel store: single write port, synchronous read port (data one cycle after address).
module pool_line_buf #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool_window_gen.sv
// Raster stream to non-overlapping 2x2 windows (stride 2, no backpressure).
// Optional POOL_ODD_PAD_EN: zero-pad the odd last column / odd last row instead of dropping it.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = POOL_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_en,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic              frame_done,
  output pool_state_e       dbg_state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  pool_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] tl_q, tl_d, bl_q, bl_d;
  logic [3:0][DATA_W-1:0] win_q, win_d;
  logic out_en_q, out_en_d;
  logic frame_done_q, frame_done_d;
  logic wr_en;
  logic [DATA_W-1:0] rd_data;
  logic col_last, row_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Read address is the next column, so linebuf[col] is already on rd_data when that pixel arrives.
  pool_line_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (col_q),
    .wr_data_i (in_data),
    .rd_addr_i (col_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    tl_d         = tl_q;
    bl_d         = bl_q;
    win_d        = win_q;
    out_en_d     = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    if (in_valid) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
      frame_done_d = col_last && row_last;
      case (state_q)
        S_FILL: begin
          wr_en = 1'b1;
          if (col_last) state_d = row_last ? S_FILL : S_PAIR;
        end
        S_PAIR: begin
          if (!col_q[0]) begin
            tl_d = rd_data;
            bl_d = in_data;
`ifdef POOL_ODD_PAD_EN
            if (col_last) begin
              out_en_d      = 1'b1;
              win_d[WIN_TL] = rd_data;
              win_d[WIN_TR] = '0;
              win_d[WIN_BL] = in_data;
              win_d[WIN_BR] = '0;
            end
`endif
          end else begin
            out_en_d      = 1'b1;
            win_d[WIN_TL] = tl_q;
            win_d[WIN_TR] = rd_data;
            win_d[WIN_BL] = bl_q;
            win_d[WIN_BR] = in_data;
          end
          if (col_last) begin
`ifdef POOL_ODD_PAD_EN
            // An even row following this odd one can only be the last row of an odd-height frame.
            state_d = (!row_last && ((row_q + RW'(1)) == ROW_LAST)) ? S_TAIL : S_FILL;
`else
            state_d = S_FILL;
`endif
          end
        end
`ifdef POOL_ODD_PAD_EN
        S_TAIL: begin
          if (!col_q[0]) begin
            tl_d = in_data;
            if (col_last) begin
              out_en_d      = 1'b1;
              win_d[WIN_TL] = in_data;
              win_d[WIN_TR] = '0;
              win_d[WIN_BL] = '0;
              win_d[WIN_BR] = '0;
            end
          end else begin
            out_en_d      = 1'b1;
            win_d[WIN_TL] = tl_q;
            win_d[WIN_TR] = in_data;
            win_d[WIN_BL] = '0;
            win_d[WIN_BR] = '0;
          end
          if (col_last) state_d = S_FILL;
        end
`endif
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      tl_q         <= '0;
      bl_q         <= '0;
      win_q        <= '0;
      out_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      tl_q         <= tl_d;
      bl_q         <= bl_d;
      win_q        <= win_d;
      out_en_q     <= out_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_en      = out_en_q;
  assign win0        = win_q[WIN_TL];
  assign win1        = win_q[WIN_TR];
  assign win2        = win_q[WIN_BL];
  assign win3        = win_q[WIN_BR];
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: 4x4 instance (a) and 5x3 instance (b), per-cycle vector tables.
module tb_pool_window_gen;
  import pool_pkg::*;

  typedef struct {
    logic             r;
    logic             v;
    logic [7:0]       d;
    logic             en;
    logic [3:0][7:0]  w;
    logic             fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv_a = 1'b0, iv_b = 1'b0;
  logic [7:0] id_a = '0, id_b = '0;
  logic en_a, en_b, fd_a, fd_b;
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
  pool_state_e st_a, st_b;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(id_a),
    .out_en(en_a), .win0(a0), .win1(a1), .win2(a2), .win3(a3),
    .frame_done(fd_a), .dbg_state_o(st_a)
  );

  pool_window_gen #(.IMG_W(5), .IMG_H(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_data(id_b),
    .out_en(en_b), .win0(b0), .win1(b1), .win2(b2), .win3(b3),
    .frame_done(fd_b), .dbg_state_o(st_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_px(input logic v, input int d);
    vec_t t;
    t.r = 1'b0; t.v = v; t.d = 8'(d); t.en = 1'b0; t.w = '0; t.fd = 1'b0;
    tbl.push_back(t);
  endtask

  task automatic add_rst();
    vec_t t;
    t.r = 1'b1; t.v = 1'b0; t.d = '0; t.en = 1'b0; t.w = '0; t.fd = 1'b0;
    tbl.push_back(t);
  endtask

  task automatic mark(input int idx, input int tl, input int tr, input int bl, input int br,
                      input logic fd);
    vec_t t;
    t = tbl[idx];
    t.en = 1'b1;
    t.w[0] = 8'(tl); t.w[1] = 8'(tr); t.w[2] = 8'(bl); t.w[3] = 8'(br);
    t.fd = fd;
    tbl[idx] = t;
  endtask

  task automatic mark_fd(input int idx);
    vec_t t;
    t = tbl[idx];
    t.fd = 1'b1;
    tbl[idx] = t;
  endtask

  // Windows of a 4x4 frame with pixels b..b+15; pixel k sits at vector idx0 + stride*k.
  task automatic mark_4x4(input int idx0, input int stride, input int b);
    mark(idx0 + 5 * stride,  b,      b + 1,  b + 4,  b + 5,  1'b0);
    mark(idx0 + 7 * stride,  b + 2,  b + 3,  b + 6,  b + 7,  1'b0);
    mark(idx0 + 13 * stride, b + 8,  b + 9,  b + 12, b + 13, 1'b0);
    mark(idx0 + 15 * stride, b + 10, b + 11, b + 14, b + 15, 1'b1);
  endtask

  // Outputs hold between windows; reset vectors clear them.
  task automatic finalize_hold();
    vec_t t;
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].en && !tbl[i].r) begin
        t = tbl[i];
        t.w = (i == 0) ? '0 : tbl[i-1].w;
        tbl[i] = t;
      end
    end
  endtask

  task automatic run_table(input int sel, input string tag);
    vec_t t;
    logic en, fd;
    logic [3:0][7:0] w;
    finalize_hold();
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge clk);
      rst = t.r;
      if (sel == 0) begin iv_a = t.v; id_a = t.d; end
      else begin iv_b = t.v; id_b = t.d; end
      @(posedge clk);
      #1;
      if (sel == 0) begin en = en_a; fd = fd_a; w = {a3, a2, a1, a0}; end
      else begin en = en_b; fd = fd_b; w = {b3, b2, b1, b0}; end
      chk($sformatf("%s[%0d].out_en", tag, i), 32'(en), 32'(t.en));
      chk($sformatf("%s[%0d].frame_done", tag, i), 32'(fd), 32'(t.fd));
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s[%0d].win%0d", tag, i, k), 32'(w[k]), 32'(t.w[k]));
    end
    @(negedge clk);
    rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0;
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.a.out_en", 32'(en_a), 0);
    chk("reset.a.frame_done", 32'(fd_a), 0);
    chk("reset.a.win", {a3, a2, a1, a0}, 0);
    chk("reset.a.state", 32'(st_a), 32'(S_FILL));
    chk("reset.b.out_en", 32'(en_b), 0);
    chk("reset.b.win", {b3, b2, b1, b0}, 0);
    chk("reset.b.state", 32'(st_b), 32'(S_FILL));
    @(negedge clk);
    rst = 1'b0;

    // First even row completes, FSM moves to pairing.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); iv_a = 1'b1; id_a = 8'(k);
    end
    @(negedge clk); iv_a = 1'b0;
    chk("row0.a.state", 32'(st_a), 32'(S_PAIR));
    do_reset();

    // 4x4 continuous.
    for (int k = 0; k < 16; k++) add_px(1'b1, k);
    add_px(1'b0, 0);
    mark_4x4(0, 1, 0);
    run_table(0, "cont");
    do_reset();

    // 4x4 with in_valid toggling.
    for (int k = 0; k < 16; k++) begin add_px(1'b1, k); add_px(1'b0, 0); end
    mark_4x4(0, 2, 0);
    run_table(0, "toggle");
    do_reset();

    // Reset after pixel 6, then a full frame 100..115.
    for (int k = 0; k < 7; k++) add_px(1'b1, k);
    mark(5, 0, 1, 4, 5, 1'b0);
    add_rst();
    for (int k = 0; k < 16; k++) add_px(1'b1, 100 + k);
    add_px(1'b0, 0);
    mark_4x4(8, 1, 100);
    run_table(0, "midrst");
    do_reset();

    // Two 4x4 frames back-to-back.
    for (int k = 0; k < 32; k++) add_px(1'b1, k);
    add_px(1'b0, 0);
    mark_4x4(0, 1, 0);
    mark_4x4(16, 1, 16);
    run_table(0, "b2b");
    do_reset();

    // 5x3, two frames back-to-back: 0..14 then 20..34.
    for (int k = 0; k < 15; k++) add_px(1'b1, k);
    for (int k = 0; k < 15; k++) add_px(1'b1, 20 + k);
    add_px(1'b0, 0);
    mark(6, 0, 1, 5, 6, 1'b0);
    mark(8, 2, 3, 7, 8, 1'b0);
    mark(21, 20, 21, 25, 26, 1'b0);
    mark(23, 22, 23, 27, 28, 1'b0);
`ifdef POOL_ODD_PAD_EN
    mark(9, 4, 0, 9, 0, 1'b0);
    mark(11, 10, 11, 0, 0, 1'b0);
    mark(13, 12, 13, 0, 0, 1'b0);
    mark(14, 14, 0, 0, 0, 1'b1);
    mark(24, 24, 0, 29, 0, 1'b0);
    mark(26, 30, 31, 0, 0, 1'b0);
    mark(28, 32, 33, 0, 0, 1'b0);
    mark(29, 34, 0, 0, 0, 1'b1);
`else
    mark_fd(14);
    mark_fd(29);
`endif
    run_table(1, "odd5x3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
